// File: rtl/three_bit_divider.sv
// Sequential 6-bit by 3-bit unsigned restoring divider.
// One quotient bit per cycle, MSB first; a zero divisor short-circuits straight to the result.
module three_bit_divider (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [5:0] dividend_i,
  input  logic [2:0] divisor_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [5:0] quotient_o,
  output logic [2:0] remainder_o,
  output logic       div_by_zero_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] prem_q, prem_d;
  logic [5:0] dvd_q, dvd_d;
  logic [2:0] dvs_q, dvs_d;
  logic [5:0] qacc_q, qacc_d;
  logic [5:0] quot_q, quot_d;
  logic [2:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic [3:0] shifted;
  logic [3:0] step_rem;
  logic       qbit;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {prem_q[2:0], dvd_q[5]};
    qbit     = (shifted >= {1'b0, dvs_q});
    step_rem = qbit ? (shifted - {1'b0, dvs_q}) : shifted;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qacc_d  = qacc_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          dvd_d = dividend_i;
          dvs_d = divisor_i;
          if (divisor_i == 3'd0) begin
            state_d = StDone;
            quot_d  = 6'b111111;
            rem_d   = 3'd0;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = StCalc;
            cnt_d   = 3'd0;
            prem_d  = 4'd0;
            qacc_d  = 6'd0;
            busy_d  = 1'b1;
          end
        end
      end
      StCalc: begin
        prem_d = step_rem;
        qacc_d = {qacc_q[4:0], qbit};
        dvd_d  = {dvd_q[4:0], 1'b0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = StDone;
          quot_d  = {qacc_q[4:0], qbit};
          rem_d   = step_rem[2:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      prem_q  <= 4'd0;
      dvd_q   <= 6'd0;
      dvs_q   <= 3'd0;
      qacc_q  <= 6'd0;
      quot_q  <= 6'd0;
      rem_q   <= 3'd0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_three_bit_divider.sv
// Self-checking bench for three_bit_divider: expected results are queued at issue time
// and popped when done is observed.
module tb_three_bit_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       dbz;

  typedef struct {
    logic [5:0] q;
    logic [2:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  three_bit_divider dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one start cycle (called at a negedge), queues the expected result,
  // then scrambles the operand inputs after the sampling edge.
  task automatic issue(input logic [5:0] a, input logic [2:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == 3'd0) begin
      e.q = 6'b111111;
      e.r = 3'd0;
      e.z = 1'b1;
    end else begin
      e.q = 6'(a / b);
      e.r = 3'(a % b);
      e.z = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 6'($urandom);
    divisor  = 3'($urandom);
  endtask

  // Waits (bounded) for done; reports elapsed cycles, busy samples seen and whether
  // the result outputs stayed unchanged until done.
  task automatic wait_done(output int cycles, output int busy_cnt, output logic held);
    logic [5:0] q0;
    logic [2:0] r0;
    logic       z0;
    q0       = quotient;
    r0       = remainder;
    z0       = dbz;
    cycles   = 0;
    busy_cnt = 0;
    held     = 1'b1;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      if (quotient !== q0 || remainder !== r0 || dbz !== z0) held = 1'b0;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 6'd45;
    divisor  = 3'd6;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, quotient, remainder, dbz} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, dbz);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    int cyc, bc;
    logic held;
    exp_t e;
    issue(6'd45, 3'd6);
    wait_done(cyc, bc, held);
    e = sb.pop_front();
    tests_run++;
    if (cyc !== 6) begin
      tests_failed++;
      $display("FAIL nominal_latency: got %0d cycles, want 6", cyc);
    end
    tests_run++;
    if (bc !== 6) begin
      tests_failed++;
      $display("FAIL nominal_busy: busy high %0d cycles, want 6", bc);
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL nominal_hold: result outputs changed during CALC, want held");
    end
    tests_run++;
    if ({quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
      tests_failed++;
      $display("FAIL nominal_result: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
               quotient, remainder, dbz, e.q, e.r, e.z);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL nominal_done_pulse: got done=%b busy=%b next cycle, want 0 0", done, busy);
    end
  endtask

  task automatic test_boundaries;
    logic [5:0] av [4] = '{6'd63, 6'd5, 6'd0, 6'd63};
    logic [2:0] bv [4] = '{3'd1, 3'd7, 3'd3, 3'd7};
    int cyc, bc;
    logic held;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(av[i], bv[i]);
      wait_done(cyc, bc, held);
      e = sb.pop_front();
      tests_run++;
      if (cyc !== 6 || {quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
        tests_failed++;
        $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d dbz=%b after %0d cycles, want q=%0d r=%0d dbz=%b after 6",
                 av[i], bv[i], quotient, remainder, dbz, cyc, e.q, e.r, e.z);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_div;
    int cyc, bc;
    logic held;
    exp_t e;
    issue(6'd20, 3'd0);
    wait_done(cyc, bc, held);
    e = sb.pop_front();
    tests_run++;
    if (cyc !== 0 || bc !== 0) begin
      tests_failed++;
      $display("FAIL zero_div_timing: got %0d cycles busy=%0d, want 0 cycles busy=0", cyc, bc);
    end
    tests_run++;
    if ({quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
      tests_failed++;
      $display("FAIL zero_div_result: got q=%b r=%b dbz=%b, want q=%b r=%b dbz=%b",
               quotient, remainder, dbz, e.q, e.r, e.z);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_div_pulse: got done=%b next cycle, want 0", done);
    end
    issue(6'd9, 3'd2);
    wait_done(cyc, bc, held);
    e = sb.pop_front();
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL zero_div_hold: previous result changed during CALC, want held at 63/0/1");
    end
    tests_run++;
    if (cyc !== 6 || {quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
      tests_failed++;
      $display("FAIL after_zero_div: got q=%0d r=%0d dbz=%b after %0d cycles, want q=%0d r=%0d dbz=%b after 6",
               quotient, remainder, dbz, cyc, e.q, e.r, e.z);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int cyc, bc, pulses;
    logic held;
    exp_t e;
    issue(6'd45, 3'd6);
    @(negedge clk);
    start    = 1'b1;
    dividend = 6'd63;
    divisor  = 3'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc, held);
    e = sb.pop_front();
    tests_run++;
    if (done !== 1'b1 || {quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
      tests_failed++;
      $display("FAIL ignored_start_result: got done=%b q=%0d r=%0d dbz=%b, want done=1 q=%0d r=%0d dbz=%b",
               done, quotient, remainder, dbz, e.q, e.r, e.z);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL ignored_start_extra_done: got %0d extra done pulses, want 0", pulses);
    end
  endtask

  task automatic test_reset_mid_op;
    int cyc, bc;
    logic held;
    exp_t e;
    issue(6'd45, 3'd6);
    e = sb.pop_back();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, quotient, remainder, dbz} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, dbz);
    end
    rst_n = 1'b1;
    issue(6'd10, 3'd3);
    wait_done(cyc, bc, held);
    e = sb.pop_front();
    tests_run++;
    if (cyc !== 6 || {quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
      tests_failed++;
      $display("FAIL after_reset: got q=%0d r=%0d dbz=%b after %0d cycles, want q=%0d r=%0d dbz=%b after 6",
               quotient, remainder, dbz, cyc, e.q, e.r, e.z);
    end
    @(negedge clk);
  endtask

  // Each start lands in the cycle after the previous done: 1 + 6 + 1 = 8 cycles per op.
  task automatic test_back_to_back;
    int cyc, bc;
    logic held;
    exp_t e;
    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 8; b++) begin
        issue(6'(a), 3'(b));
        wait_done(cyc, bc, held);
        e = sb.pop_front();
        tests_run++;
        if (cyc !== 6 || {quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
          tests_failed++;
          $display("FAIL exhaustive_%0d_%0d: got q=%0d r=%0d dbz=%b after %0d cycles, want q=%0d r=%0d dbz=0 after 6",
                   a, b, quotient, remainder, dbz, cyc, e.q, e.r);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
          tests_failed++;
          $display("FAIL exhaustive_pulse_%0d_%0d: got done=%b one cycle later, want 0", a, b, done);
        end
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 6'd0;
    divisor  = 3'd0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_boundaries();
    test_zero_div();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending results, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/three_bit_divider.md
THREE_BIT_DIVIDER -- requirements
Module: three_bit_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (6-bit dividend and quotient, 3-bit divisor and remainder), matching the 3x3->6 product width of the team's multiplier.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  6  unsigned numerator; sampled with start.
REQ-006 divisor  input  3  unsigned denominator; sampled with start.
REQ-007 busy  output  1  high while state is CALC.
REQ-008 done  output  1  single-cycle result-valid pulse.
REQ-009 quotient  output  6  registered unsigned quotient.
REQ-010 remainder  output  3  registered unsigned remainder.
REQ-011 div_by_zero  output  1  registered flag; high when the last accepted divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 at edge k SHALL latch dividend and divisor internally.
REQ-014 If the latched divisor is nonzero, the FSM SHALL enter CALC at edge k and clear the 3-bit iteration counter and the 4-bit partial remainder.
REQ-015 If the latched divisor is 0, the FSM SHALL enter DONE at edge k with quotient=6'b111111, remainder=3'b000, div_by_zero=1 and done=1.
REQ-016 Each CALC edge SHALL perform one restoring step, MSB first: shift the next dividend bit into the partial remainder, then compare with the zero-extended divisor.
REQ-017 When the shifted partial remainder is >= the divisor, the step SHALL subtract the divisor and set quotient bit 1; otherwise it SHALL restore (keep the value) and set quotient bit 0.
REQ-018 CALC SHALL run exactly 6 steps (edges k+1..k+6).
REQ-019 At edge k+6 the FSM SHALL enter DONE and load quotient, remainder (partial remainder[2:0]), div_by_zero=0 and done=1.
REQ-020 Latency SHALL be 6 cycles from the start edge to done high for a nonzero divisor, and 0 extra cycles (done visible right after edge k) for a zero divisor.
REQ-021 DONE SHALL return to IDLE on the next edge unconditionally; done SHALL be high for exactly one cycle.
REQ-022 start SHALL be ignored in CALC and DONE; no queuing.
REQ-023 quotient, remainder and div_by_zero SHALL hold their last values until the next result load or reset; they SHALL NOT change during CALC.
REQ-024 Results SHALL equal floor(dividend/divisor) and dividend mod divisor for every one of the 64x7 nonzero-divisor pairs.
REQ-025 Inputs changing after the start edge SHALL NOT affect the result.
REQ-026 The block SHALL contain no latches and no combinational path from inputs to outputs.

Reset
REQ-027 On rst_n=0 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and partial remainder.
REQ-028 Reset SHALL take priority over start and over any CALC step.
REQ-029 Reset asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-030 After rst_n returns to 1, start SHALL be accepted on the first edge it is high.

Verification
REQ-031 Nominal: dividend=45 (101101), divisor=6 -> busy high for 6 cycles, then done=1 for one cycle, quotient=7, remainder=3, div_by_zero=0.
REQ-032 Boundaries: 63/1 -> q=63, r=0; 5/7 -> q=0, r=5; 0/3 -> q=0, r=0; 63/7 -> q=9, r=0.
REQ-033 Zero divisor: 20/0 -> done on the cycle after start, q=111111, r=000, div_by_zero=1, busy never high; a following 9/2 -> q=4, r=1, div_by_zero=0.
REQ-034 Ignored start: 45/6 in flight, then start with 63/1 at cycle 3 -> only one done pulse, with q=7, r=3.
REQ-035 Reset mid-op: 45/6 started, rst_n=0 at cycle 3 -> next cycle all outputs 0, state IDLE, no done pulse; a following 10/3 -> q=3, r=1 after 6 cycles.
REQ-036 Exhaustive: all 448 nonzero-divisor pairs issued back-to-back, each start in the cycle after its done -> every result matches the reference model, with exactly 8 cycles per operation.
